// File: rtl/start_light_seq.sv
// -----------------------------------------------------------------------------
// start_light_seq
//
// Start-light sequencer for the starting-line reaction game. Counts 1 ms ticks
// to light the start lights one per step, holds them all on for a fixed plus
// pseudo-random delay, turns them off ("go"), then measures the player's
// reaction time in ms. A press before "go" is reported as a false start.
//
// Ports:
//   i_clk          system clock
//   i_rst_n        synchronous, active-low reset
//   i_tick         one-cycle 1 ms strobe from the clock divider
//   i_start        one-cycle start request
//   i_react        one-cycle reaction press
//   o_lights       start lights, bit 0 lights first
//   o_busy         sequence or measurement in progress
//   o_valid        o_time_ms holds a valid result
//   o_false_start  last attempt was a press before "go"
//   o_time_ms      measured reaction time in ms (saturating)
//   o_best_ms      best reaction time since reset (only with the option below)
//
// Optional feature:
//   START_LIGHT_SEQ_BEST_EN  adds o_best_ms and the best-time register.
// -----------------------------------------------------------------------------
module start_light_seq #(
    parameter int NUM_LIGHTS  = 5,
    parameter int STEP_MS     = 1000,
    parameter int MIN_HOLD_MS = 200,
    parameter int RAND_W      = 12,
    parameter int TIME_W      = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_tick,
    input  logic                  i_start,
    input  logic                  i_react,
    output logic [NUM_LIGHTS-1:0] o_lights,
    output logic                  o_busy,
    output logic                  o_valid,
    output logic                  o_false_start,
`ifdef START_LIGHT_SEQ_BEST_EN
    output logic [TIME_W-1:0]     o_best_ms,
`endif
    output logic [TIME_W-1:0]     o_time_ms
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LIGHTS,
        S_HOLD,
        S_GO,
        S_DONE,
        S_FALSE
    } state_t;

    localparam logic [NUM_LIGHTS-1:0] ALL_ON    = {NUM_LIGHTS{1'b1}};
    localparam logic [NUM_LIGHTS-1:0] FIRST_ON  = NUM_LIGHTS'(1);
    localparam logic [TIME_W-1:0]     STEP_LAST = TIME_W'(STEP_MS - 1);
    localparam logic [TIME_W-1:0]     MIN_HOLD  = TIME_W'(MIN_HOLD_MS);
    localparam logic [TIME_W-1:0]     CNT_MAX   = {TIME_W{1'b1}};
    localparam logic [15:0]           LFSR_SEED = 16'hACE1;

    state_t                  state_q, state_d;
    logic [NUM_LIGHTS-1:0]   lights_q, lights_d;
    logic                    busy_q, busy_d;
    logic                    valid_q, valid_d;
    logic                    false_q, false_d;
    logic [TIME_W-1:0]       time_q, time_d;
    logic [TIME_W-1:0]       cnt_q, cnt_d;
    logic [TIME_W-1:0]       target_q, target_d;
    logic [15:0]             lfsr_q, lfsr_d;
`ifdef START_LIGHT_SEQ_BEST_EN
    logic [TIME_W-1:0]       best_q, best_d;
`endif

    logic hold_done;

    // A zero target (only reachable with MIN_HOLD_MS=0) ends the hold on the
    // first tick instead of waiting for the counter to wrap.
    assign hold_done = (target_q == '0) || (cnt_q == target_q - 1'b1);

    // Next-state and next-output logic. A press before "go" always wins over
    // a tick arriving in the same cycle, so it is tested first.
    always_comb begin
        state_d  = state_q;
        lights_d = lights_q;
        busy_d   = busy_q;
        valid_d  = valid_q;
        false_d  = false_q;
        time_d   = time_q;
        cnt_d    = cnt_q;
        target_d = target_q;
`ifdef START_LIGHT_SEQ_BEST_EN
        best_d   = best_q;
`endif
        // Fibonacci LFSR, taps 16,14,13,11, free-running every cycle.
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

        case (state_q)
            S_IDLE, S_DONE, S_FALSE: begin
                if (i_start) begin
                    state_d  = S_LIGHTS;
                    lights_d = FIRST_ON;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    valid_d  = 1'b0;
                    false_d  = 1'b0;
                end
            end
            S_LIGHTS: begin
                if (i_react) begin
                    state_d  = S_FALSE;
                    lights_d = ALL_ON;
                    false_d  = 1'b1;
                    busy_d   = 1'b0;
                    valid_d  = 1'b0;
                end else if (i_tick) begin
                    if (cnt_q == STEP_LAST) begin
                        cnt_d = '0;
                        if (lights_q != ALL_ON) begin
                            lights_d = (lights_q << 1) | FIRST_ON;
                        end else begin
                            state_d  = S_HOLD;
                            target_d = MIN_HOLD + TIME_W'(lfsr_q[RAND_W-1:0]);
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (i_react) begin
                    state_d  = S_FALSE;
                    lights_d = ALL_ON;
                    false_d  = 1'b1;
                    busy_d   = 1'b0;
                    valid_d  = 1'b0;
                end else if (i_tick) begin
                    if (hold_done) begin
                        state_d  = S_GO;
                        lights_d = '0;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_GO: begin
                // The reported time is the count before any same-cycle tick.
                if (i_react) begin
                    state_d = S_DONE;
                    time_d  = cnt_q;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
`ifdef START_LIGHT_SEQ_BEST_EN
                    if (cnt_q < best_q) begin
                        best_d = cnt_q;
                    end
`endif
                end else if (i_tick && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset aborts any sequence in progress.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            lights_q <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            false_q  <= 1'b0;
            time_q   <= '0;
            cnt_q    <= '0;
            target_q <= '0;
            lfsr_q   <= LFSR_SEED;
`ifdef START_LIGHT_SEQ_BEST_EN
            best_q   <= CNT_MAX;
`endif
        end else begin
            state_q  <= state_d;
            lights_q <= lights_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            false_q  <= false_d;
            time_q   <= time_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            lfsr_q   <= lfsr_d;
`ifdef START_LIGHT_SEQ_BEST_EN
            best_q   <= best_d;
`endif
        end
    end

    assign o_lights      = lights_q;
    assign o_busy        = busy_q;
    assign o_valid       = valid_q;
    assign o_false_start = false_q;
    assign o_time_ms     = time_q;
`ifdef START_LIGHT_SEQ_BEST_EN
    assign o_best_ms     = best_q;
`endif

endmodule
